// File: rtl/wash_cycle_seq.sv
// Washer program sequencer: fill/agitate/drain/spin steps on a 1 s tick.
// Optional end-of-cycle buzzer is built when WASH_BUZZER_EN is defined.
module wash_cycle_seq #(
  parameter int TICK_DIV = 100000000,
  parameter int FILL_S   = 3,
  parameter int WASH_S   = 12,
  parameter int RINSE_S  = 6,
  parameter int DRAIN_S  = 3,
  parameter int SPIN_S   = 6,
  parameter int BUZZ_S   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] mode,
  input  logic       pause,
  input  logic       door_open,
  output logic       valve,
  output logic       pump,
  output logic       motor_fwd,
  output logic       motor_rev,
  output logic [1:0] phase,
  output logic [7:0] rem_s,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       buzzer
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_AGIT, S_DRAIN, S_SPIN, S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic          rinse_q, rinse_d;
  logic [1:0]    mode_q, mode_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [7:0]    rem_q, rem_d;
  logic [2:0]    agit_q, agit_d;
  logic          valve_d, pump_d, fwd_d, rev_d;
  logic          busy_d, done_d, err_d;
  logic [1:0]    phase_d;
  logic          run, hold, tick;

  function automatic logic [7:0] fill_len(input logic [1:0] m);
    return 8'(FILL_S * int'(m));
  endfunction

  function automatic logic [7:0] prog_len(input logic [1:0] m);
    if (m == 2'd0) return 8'(DRAIN_S + SPIN_S);
    return 8'(2 * FILL_S * int'(m) + WASH_S + RINSE_S
              + 2 * DRAIN_S + SPIN_S);
  endfunction

  assign run  = (state_q == S_FILL) || (state_q == S_AGIT) ||
                (state_q == S_DRAIN) || (state_q == S_SPIN);
  assign hold = run & (pause | door_open);
  assign tick = ~hold & (presc_q == PMAX);
  assign rem_s = rem_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      rinse_q   <= 1'b0;
      mode_q    <= 2'd0;
      presc_q   <= '0;
      cnt_q     <= 8'd0;
      rem_q     <= 8'd0;
      agit_q    <= 3'd0;
      valve     <= 1'b0;
      pump      <= 1'b0;
      motor_fwd <= 1'b0;
      motor_rev <= 1'b0;
      phase     <= 2'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      rinse_q   <= rinse_d;
      mode_q    <= mode_d;
      presc_q   <= presc_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      agit_q    <= agit_d;
      valve     <= valve_d;
      pump      <= pump_d;
      motor_fwd <= fwd_d;
      motor_rev <= rev_d;
      phase     <= phase_d;
      busy      <= busy_d;
      done      <= done_d;
      err       <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rinse_d = rinse_q;
    mode_d  = mode_q;
    presc_d = presc_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    agit_d  = agit_q;
    if (!hold) presc_d = tick ? '0 : presc_q + 1'b1;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          presc_d = '0;
          mode_d  = mode;
          rinse_d = 1'b0;
          rem_d   = prog_len(mode);
          agit_d  = 3'd0;
          if (mode == 2'd0) begin
            state_d = S_DRAIN;
            cnt_d   = 8'(DRAIN_S);
          end else begin
            state_d = S_FILL;
            cnt_d   = fill_len(mode);
          end
        end
      end
      S_FILL, S_AGIT, S_DRAIN, S_SPIN: begin
        if (tick) begin
          rem_d  = (rem_q == 8'd0) ? 8'd0 : rem_q - 8'd1;
          cnt_d  = cnt_q - 8'd1;
          agit_d = (agit_q == 3'd5) ? 3'd0 : agit_q + 3'd1;
          if (cnt_q == 8'd1) begin
            agit_d = 3'd0;
            unique case (state_q)
              S_FILL: begin
                state_d = S_AGIT;
                cnt_d   = rinse_q ? 8'(RINSE_S) : 8'(WASH_S);
              end
              S_AGIT: begin
                state_d = S_DRAIN;
                cnt_d   = 8'(DRAIN_S);
              end
              S_DRAIN: begin
                if (rinse_q || mode_q == 2'd0) begin
                  state_d = S_SPIN;
                  cnt_d   = 8'(SPIN_S);
                end else begin
                  state_d = S_FILL;
                  rinse_d = 1'b1;
                  cnt_d   = fill_len(mode_q);
                end
              end
              default: begin
                state_d = S_DONE;
                cnt_d   = 8'd0;
                rem_d   = 8'd0;
              end
            endcase
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Actuators follow the next state but are masked while held.
  always_comb begin
    valve_d = 1'b0;
    pump_d  = 1'b0;
    fwd_d   = 1'b0;
    rev_d   = 1'b0;
    phase_d = 2'd0;
    busy_d  = (state_d == S_FILL) || (state_d == S_AGIT) ||
              (state_d == S_DRAIN) || (state_d == S_SPIN);
    done_d  = (state_d == S_DONE);
    err_d   = door_open & run;
    unique case (1'b1)
      state_d == S_FILL: begin
        valve_d = ~hold;
        phase_d = rinse_d ? 2'd2 : 2'd1;
      end
      state_d == S_AGIT: begin
        fwd_d   = ~hold & (agit_d < 3'd2);
        rev_d   = ~hold & ((agit_d == 3'd3) || (agit_d == 3'd4));
        phase_d = rinse_d ? 2'd2 : 2'd1;
      end
      state_d == S_DRAIN: begin
        pump_d  = ~hold;
        phase_d = (mode_d == 2'd0) ? 2'd3 : (rinse_d ? 2'd2 : 2'd1);
      end
      state_d == S_SPIN: begin
        fwd_d   = ~hold;
        pump_d  = ~hold;
        phase_d = 2'd3;
      end
      default: ;
    endcase
  end

`ifdef WASH_BUZZER_EN
  logic [7:0] buzz_q, buzz_d;
  logic       buzzer_q;

  always_comb begin
    buzz_d = buzz_q;
    if (state_q == S_SPIN && state_d == S_DONE) begin
      buzz_d = 8'(BUZZ_S);
    end else if (state_q == S_DONE) begin
      if (start) buzz_d = 8'd0;
      else if (tick && buzz_q != 8'd0) buzz_d = buzz_q - 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buzz_q   <= 8'd0;
      buzzer_q <= 1'b0;
    end else begin
      buzz_q   <= buzz_d;
      buzzer_q <= (state_d == S_DONE) && (buzz_d != 8'd0);
    end
  end

  assign buzzer = buzzer_q;
`else
  assign buzzer = 1'b0;
`endif

endmodule

// File: tb/tb_wash_cycle_seq.sv
// Bench for wash_cycle_seq: vector table, corner sequences and a
// step-queue reference model checked every cycle under random stimulus.
module tb_wash_cycle_seq;
  localparam int TD = 4;
  localparam int FILL_S = 3, WASH_S = 12, RINSE_S = 6;
  localparam int DRAIN_S = 3, SPIN_S = 6, BUZZ_S = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [1:0] mode = 2'd0;
  logic       pause = 1'b0;
  logic       door_open = 1'b0;
  logic       valve, pump, motor_fwd, motor_rev;
  logic [1:0] phase;
  logic [7:0] rem_s;
  logic       busy, done, err, buzzer;

  wash_cycle_seq #(.TICK_DIV(TD)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .pause(pause), .door_open(door_open),
    .valve(valve), .pump(pump),
    .motor_fwd(motor_fwd), .motor_rev(motor_rev),
    .phase(phase), .rem_s(rem_s), .busy(busy), .done(done),
    .err(err), .buzzer(buzzer)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %0h expected %0h at %0t",
                 name, act, exp, $time);
    end
  endtask

  function automatic int outs();
    return int'({valve, pump, motor_fwd, motor_rev, phase,
                 busy, done, err, buzzer});
  endfunction

  // Reference model: the program as a queue of {kind, seconds, phase}.
  typedef struct { int kind; int dur; int ph; } step_t;
  step_t q[$];
  int m_sub, m_el, m_rem, m_buzz;
  bit m_busy, m_done, m_err, held;
  int e_outs;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      m_sub = 0; m_el = 0; m_rem = 0; m_buzz = 0;
      m_busy = 0; m_done = 0; m_err = 0;
      e_outs = 0;
    end else begin
      held = m_busy && (pause || door_open);
      m_err = door_open && m_busy;
      if (!m_busy) begin
        if (start) begin
          q.delete();
          if (mode == 2'd0) begin
            q.push_back('{3, DRAIN_S, 3});
            q.push_back('{4, SPIN_S, 3});
          end else begin
            q.push_back('{1, FILL_S * int'(mode), 1});
            q.push_back('{2, WASH_S, 1});
            q.push_back('{3, DRAIN_S, 1});
            q.push_back('{1, FILL_S * int'(mode), 2});
            q.push_back('{2, RINSE_S, 2});
            q.push_back('{3, DRAIN_S, 2});
            q.push_back('{4, SPIN_S, 3});
          end
          m_rem = 0;
          foreach (q[k]) m_rem += q[k].dur;
          m_busy = 1; m_done = 0; m_sub = 0; m_el = 0; m_buzz = 0;
        end else if (m_done) begin
          m_sub++;
          if (m_sub == TD) begin
            m_sub = 0;
            if (m_buzz > 0) m_buzz--;
          end
        end
      end else if (!held) begin
        m_sub++;
        if (m_sub == TD) begin
          m_sub = 0;
          if (m_rem > 0) m_rem--;
          m_el++;
          if (m_el == q[0].dur) begin
            void'(q.pop_front());
            m_el = 0;
            if (q.size() == 0) begin
              m_busy = 0; m_done = 1; m_rem = 0; m_buzz = BUZZ_S;
            end
          end
        end
      end
      begin
        bit v, p, f, r, b;
        int ph, s;
        v = 0; p = 0; f = 0; r = 0; ph = 0; b = 0;
        if (m_busy) begin
          ph = q[0].ph;
          s = m_el % 6;
          case (q[0].kind)
            1: v = !held;
            2: begin f = !held && s < 2; r = !held && (s == 3 || s == 4); end
            3: p = !held;
            default: begin f = !held; p = !held; end
          endcase
        end
`ifdef WASH_BUZZER_EN
        b = m_done && m_buzz > 0;
`endif
        e_outs = int'({v, p, f, r, 2'(ph), m_busy, m_done, m_err, b});
      end
    end
  end

  always @(negedge clk) begin
    if (rst && chk_en) begin
      chk("model_outs", outs(), e_outs);
      chk("model_rem", int'(rem_s), m_rem);
    end
  end

  typedef struct {
    logic [1:0] md;
    int rem0;
    int cycles;
    int valve_cyc;
  } vec_t;

  vec_t tbl[4];
  int n, vc, bc, r0;
  int exp_buzz;

  task automatic launch(input logic [1:0] md);
    @(negedge clk);
    start = 1'b1;
    mode = md;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run_to_done(input int limit);
    while (!done && n < limit) begin
      @(posedge clk);
      #1;
      n++;
      vc += int'(valve);
    end
  endtask

  initial begin
`ifdef WASH_BUZZER_EN
    exp_buzz = 4 * BUZZ_S;
`else
    exp_buzz = 0;
`endif
    tbl[0] = '{2'd1, 36, 144, 24};
    tbl[1] = '{2'd2, 42, 168, 48};
    tbl[2] = '{2'd3, 48, 192, 72};
    tbl[3] = '{2'd0, 9, 36, 0};

    repeat (3) @(negedge clk);
    chk("reset_outs", outs(), 0);
    chk("reset_rem", int'(rem_s), 0);
    rst = 1'b1;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);

    foreach (tbl[i]) begin
      launch(tbl[i].md);
      chk("start_rem", int'(rem_s), tbl[i].rem0);
      chk("start_busy", int'(busy), 1);
      n = 0;
      vc = int'(valve);
      run_to_done(1000);
      chk("prog_cycles", n, tbl[i].cycles);
      chk("valve_cycles", vc, tbl[i].valve_cyc);
      chk("done_rem", int'(rem_s), 0);
      chk("done_phase", int'(phase), 0);
      bc = int'(buzzer);
      repeat (19) begin
        @(posedge clk);
        #1 bc += int'(buzzer);
      end
      chk("buzz_cycles", bc, exp_buzz);
    end

    // pause mid-agitate during reverse drive
    launch(2'd1);
    n = 0;
    vc = 0;
    repeat (26) begin @(posedge clk); #1 n++; end
    chk("pre_pause_rev", int'(motor_rev), 1);
    r0 = int'(rem_s);
    pause = 1'b1;
    repeat (20) begin @(posedge clk); #1 n++; end
    chk("pause_act", int'({valve, pump, motor_fwd, motor_rev}), 0);
    chk("pause_rem", int'(rem_s), r0);
    pause = 1'b0;
    @(posedge clk);
    #1 n++;
    chk("resume_rev", int'(motor_rev), 1);
    run_to_done(1000);
    chk("pause_cycles", n, 164);

    // door open during spin, with an ignored start pulse
    launch(2'd0);
    n = 0;
    repeat (20) begin @(posedge clk); #1 n++; end
    chk("spin_fwd", int'(motor_fwd), 1);
    door_open = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1 n++;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1 n++; end
    chk("door_err", int'(err), 1);
    chk("door_motor", int'(motor_fwd | pump), 0);
    chk("door_busy", int'(busy), 1);
    door_open = 1'b0;
    @(posedge clk);
    #1 n++;
    chk("door_clr", int'(err), 0);
    chk("door_resume", int'(motor_fwd), 1);
    run_to_done(1000);
    chk("door_cycles", n, 41);

    // asynchronous reset in the middle of a fill
    launch(2'd1);
    repeat (5) @(posedge clk);
    #2 rst = 1'b0;
    #1 chk("midrst_outs", outs(), 0);
    chk("midrst_rem", int'(rem_s), 0);
    @(negedge clk);
    rst = 1'b1;
    launch(2'd3);
    chk("rst_start_rem", int'(rem_s), 48);
    vc = 0;
    n = 0;
    while (valve && n < 100) begin
      vc++;
      @(posedge clk);
      #1 n++;
    end
    chk("fill_l_cycles", vc, 36);
    n = 0;
    run_to_done(1000);
    chk("rst_run_done", int'(done), 1);

    // random front-panel activity against the model
    for (int r = 0; r < 6; r++) begin
      launch(2'($urandom_range(0, 3)));
      for (int c = 0; c < 300; c++) begin
        @(negedge clk);
        if ($urandom_range(0, 11) == 0) pause = ~pause;
        if ($urandom_range(0, 29) == 0) door_open = ~door_open;
        start = ($urandom_range(0, 39) == 0);
        mode = 2'($urandom_range(0, 3));
      end
      @(negedge clk);
      pause = 1'b0;
      door_open = 1'b0;
      start = 1'b0;
      n = 0;
      run_to_done(1000);
      chk("rand_done", int'(done), 1);
    end

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
